// File: rtl/error_report_arbiter.sv
// Collects single-cycle error pulses from independent detectors into one-entry
// slots and drains them round-robin to the logger, one record per cycle.
module error_report_arbiter #(
  parameter int         NUM_SRC     = 4,
  parameter logic [7:0] SRC_ID_BASE = 8'h10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*8-1:0]    src_code,
  input  logic [NUM_SRC*12-1:0]   src_txn_id,
  input  logic [NUM_SRC*48-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]      src_enable,
  input  logic [NUM_SRC-1:0]      overflow_clr,
  output logic                    error_valid,
  output logic [7:0]              error_code,
  output logic [11:0]             error_txn_id,
  output logic [47:0]             error_addr,
  output logic [7:0]              error_source_id,
  output logic [NUM_SRC-1:0]      pending,
  output logic [NUM_SRC-1:0]      overflow,
  output logic [15:0]             drop_count
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(NUM_SRC + 1);

  logic [7:0]  slot_code [NUM_SRC];
  logic [11:0] slot_txn  [NUM_SRC];
  logic [47:0] slot_addr [NUM_SRC];

  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [NUM_SRC-1:0] capture;
  logic [NUM_SRC-1:0] granted;
  logic [NUM_SRC-1:0] drop;
  logic [CNT_W-1:0]   drop_num;
  logic [16:0]        drop_sum;

  // Round-robin search begins just after the most recently granted source.
  always_comb begin
    logic [IDX_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % NUM_SRC);
      if (!grant_vld && pending[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    capture  = '0;
    granted  = '0;
    drop     = '0;
    drop_num = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      capture[i] = src_valid[i] & src_enable[i] & (src_code[i*8 +: 8] != 8'h00);
      granted[i] = grant_vld && (grant_idx == IDX_W'(i));
      // A slot being granted this edge is free to take the new record.
      drop[i]    = capture[i] & pending[i] & ~granted[i];
      drop_num   = drop_num + CNT_W'(drop[i]);
    end
  end

  assign drop_sum = {1'b0, drop_count} + 17'(drop_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_valid     <= 1'b0;
      error_code      <= '0;
      error_txn_id    <= '0;
      error_addr      <= '0;
      error_source_id <= '0;
      pending         <= '0;
      overflow        <= '0;
      drop_count      <= '0;
      last_grant      <= IDX_W'(NUM_SRC - 1);
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_code[i] <= '0;
        slot_txn[i]  <= '0;
        slot_addr[i] <= '0;
      end
    end else begin
      error_valid <= grant_vld;
      if (grant_vld) begin
        error_code      <= slot_code[grant_idx];
        error_txn_id    <= slot_txn[grant_idx];
        error_addr      <= slot_addr[grant_idx];
        error_source_id <= SRC_ID_BASE + 8'(grant_idx);
        last_grant      <= grant_idx;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (capture[i] && (!pending[i] || granted[i])) begin
          slot_code[i] <= src_code[i*8 +: 8];
          slot_txn[i]  <= src_txn_id[i*12 +: 12];
          slot_addr[i] <= src_addr[i*48 +: 48];
          pending[i]   <= 1'b1;
        end else if (granted[i]) begin
          pending[i] <= 1'b0;
        end
        if (drop[i])
          overflow[i] <= 1'b1;
        else if (overflow_clr[i])
          overflow[i] <= 1'b0;
      end
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_error_report_arbiter.sv
// Self-checking bench for error_report_arbiter: directed vector table, corner
// sequences, and randomized traffic against a behavioural slot/queue model.
module tb_error_report_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N*8-1:0]  src_code = '0;
  logic [N*12-1:0] src_txn_id = '0;
  logic [N*48-1:0] src_addr = '0;
  logic [N-1:0]    src_enable = '1;
  logic [N-1:0]    overflow_clr = '0;
  logic            error_valid;
  logic [7:0]      error_code;
  logic [11:0]     error_txn_id;
  logic [47:0]     error_addr;
  logic [7:0]      error_source_id;
  logic [N-1:0]    pending;
  logic [N-1:0]    overflow;
  logic [15:0]     drop_count;

  int checks = 0;
  int errors = 0;

  error_report_arbiter #(.NUM_SRC(N), .SRC_ID_BASE(8'h10)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_code(src_code),
    .src_txn_id(src_txn_id), .src_addr(src_addr), .src_enable(src_enable),
    .overflow_clr(overflow_clr), .error_valid(error_valid), .error_code(error_code),
    .error_txn_id(error_txn_id), .error_addr(error_addr),
    .error_source_id(error_source_id), .pending(pending), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [7:0] c, input logic [11:0] t, input logic [47:0] a);
    src_code[i*8 +: 8]     = c;
    src_txn_id[i*12 +: 12] = t;
    src_addr[i*48 +: 48]   = a;
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic apply(input logic [N-1:0] v, input logic [N-1:0] en, input logic [N-1:0] clr);
    src_valid    = v;
    src_enable   = en;
    overflow_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_valid = '0;
    overflow_clr = '0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  valid, en, clr;
    logic [7:0]  code;
    logic        ev;
    logic [7:0]  sid, ecode;
    logic [3:0]  pend, ovf;
    logic [15:0] drop;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] en, input logic [3:0] clr,
                              input logic [7:0] c, input logic ev, input logic [7:0] sid,
                              input logic [7:0] ec, input logic [3:0] p, input logic [3:0] o,
                              input logic [15:0] d);
    vec_t r;
    r.valid = v; r.en = en; r.clr = clr; r.code = c; r.ev = ev; r.sid = sid;
    r.ecode = ec; r.pend = p; r.ovf = o; r.drop = d;
    return r;
  endfunction

  // Behavioural reference: a one-entry queue per source plus a round-robin pointer.
  int          m_last;
  bit          m_pend [N];
  logic [7:0]  m_code [N];
  logic [11:0] m_txn  [N];
  logic [47:0] m_addr [N];
  bit          m_ovf  [N];
  int          m_drop;
  bit          m_ev;
  logic [7:0]  m_ocode, m_osid;
  logic [11:0] m_otxn;
  logic [47:0] m_oaddr;

  task automatic model_reset();
    m_last = N - 1;
    m_drop = 0;
    m_ev = 0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_ovf[i] = 0;
    end
  endtask

  task automatic model_step();
    int g;
    bit cap, dropped;
    g = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
    m_ev = (g >= 0);
    if (g >= 0) begin
      m_ocode = m_code[g];
      m_otxn = m_txn[g];
      m_oaddr = m_addr[g];
      m_osid = 8'h10 + 8'(g);
      m_pend[g] = 0;
      m_last = g;
    end
    for (int i = 0; i < N; i++) begin
      cap = src_valid[i] && src_enable[i] && (src_code[i*8 +: 8] != 0);
      dropped = cap && m_pend[i];
      if (dropped) begin
        m_ovf[i] = 1;
        if (m_drop < 65535) m_drop++;
      end else begin
        if (cap) begin
          m_pend[i] = 1;
          m_code[i] = src_code[i*8 +: 8];
          m_txn[i] = src_txn_id[i*12 +: 12];
          m_addr[i] = src_addr[i*48 +: 48];
        end
        if (overflow_clr[i]) m_ovf[i] = 0;
      end
    end
  endtask

  vec_t tbl[17];

  initial begin
    logic [3:0] mp, mo;
    logic [15:0] d0;

    tbl[0]  = mk(4'b1111, 4'hF, 4'h0, 8'h05, 0, 8'h00, 8'h00, 4'b1111, 4'b0000, 16'd0);
    tbl[1]  = mk(4'b0000, 4'hF, 4'h0, 8'h05, 1, 8'h10, 8'h05, 4'b1110, 4'b0000, 16'd0);
    tbl[2]  = mk(4'b0000, 4'hF, 4'h0, 8'h05, 1, 8'h11, 8'h05, 4'b1100, 4'b0000, 16'd0);
    tbl[3]  = mk(4'b0000, 4'hF, 4'h0, 8'h05, 1, 8'h12, 8'h05, 4'b1000, 4'b0000, 16'd0);
    tbl[4]  = mk(4'b0000, 4'hF, 4'h0, 8'h05, 1, 8'h13, 8'h05, 4'b0000, 4'b0000, 16'd0);
    tbl[5]  = mk(4'b1001, 4'hF, 4'h0, 8'h06, 0, 8'h00, 8'h00, 4'b1001, 4'b0000, 16'd0);
    tbl[6]  = mk(4'b0000, 4'hF, 4'h0, 8'h06, 1, 8'h10, 8'h06, 4'b1000, 4'b0000, 16'd0);
    tbl[7]  = mk(4'b0000, 4'hF, 4'h0, 8'h06, 1, 8'h13, 8'h06, 4'b0000, 4'b0000, 16'd0);
    tbl[8]  = mk(4'b0010, 4'hF, 4'h0, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 16'd0);
    tbl[9]  = mk(4'b0000, 4'hF, 4'h0, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 16'd0);
    tbl[10] = mk(4'b0100, 4'hF, 4'h0, 8'h01, 0, 8'h00, 8'h00, 4'b0100, 4'b0000, 16'd0);
    tbl[11] = mk(4'b0000, 4'hF, 4'h0, 8'h01, 1, 8'h12, 8'h01, 4'b0000, 4'b0000, 16'd0);
    tbl[12] = mk(4'b0011, 4'hF, 4'h0, 8'h07, 0, 8'h00, 8'h00, 4'b0011, 4'b0000, 16'd0);
    tbl[13] = mk(4'b0010, 4'hF, 4'h0, 8'h08, 1, 8'h10, 8'h07, 4'b0010, 4'b0010, 16'd1);
    tbl[14] = mk(4'b0000, 4'hF, 4'h0, 8'h08, 1, 8'h11, 8'h07, 4'b0000, 4'b0010, 16'd1);
    tbl[15] = mk(4'b0000, 4'hF, 4'h2, 8'h08, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 16'd1);
    tbl[16] = mk(4'b0001, 4'hE, 4'h0, 8'h0A, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 16'd1);

    #2;
    chk("reset_valid", 64'(error_valid), 64'd0);
    chk("reset_pending", 64'(pending), 64'd0);
    chk("reset_drop", 64'(drop_count), 64'd0);
    chk("reset_sid", 64'(error_source_id), 64'd0);
    do_reset();

    foreach (tbl[n]) begin
      for (int i = 0; i < N; i++)
        set_src(i, tbl[n].code, {4'(i), 8'(n)}, 48'h1000 * (i + 1) + 48'(n));
      apply(tbl[n].valid, tbl[n].en, tbl[n].clr);
      chk($sformatf("vec%0d_valid", n), 64'(error_valid), 64'(tbl[n].ev));
      chk($sformatf("vec%0d_pending", n), 64'(pending), 64'(tbl[n].pend));
      chk($sformatf("vec%0d_overflow", n), 64'(overflow), 64'(tbl[n].ovf));
      chk($sformatf("vec%0d_drop", n), 64'(drop_count), 64'(tbl[n].drop));
      if (tbl[n].ev) begin
        chk($sformatf("vec%0d_sid", n), 64'(error_source_id), 64'(tbl[n].sid));
        chk($sformatf("vec%0d_code", n), 64'(error_code), 64'(tbl[n].ecode));
      end
    end

    // Single report with exact field values.
    set_src(2, 8'h01, 12'h0A5, 48'h1000);
    apply(4'b0100, 4'hF, 4'h0);
    chk("single_pend", 64'(pending), 64'b0100);
    chk("single_early", 64'(error_valid), 64'd0);
    apply(4'b0000, 4'hF, 4'h0);
    chk("single_valid", 64'(error_valid), 64'd1);
    chk("single_code", 64'(error_code), 64'h01);
    chk("single_txn", 64'(error_txn_id), 64'h0A5);
    chk("single_addr", 64'(error_addr), 64'h1000);
    chk("single_sid", 64'(error_source_id), 64'h12);
    chk("single_pend_clr", 64'(pending), 64'd0);
    apply(4'b0000, 4'hF, 4'h0);
    chk("single_pulse", 64'(error_valid), 64'd0);

    // Source 0 every cycle: grant-and-refill, no drops.
    d0 = drop_count;
    for (int c = 0; c < 8; c++) begin
      set_src(0, 8'h03, 12'h100 + 12'(c), 48'h2000);
      apply(4'b0001, 4'hF, 4'h0);
      if (c >= 1) begin
        chk($sformatf("stream%0d_valid", c), 64'(error_valid), 64'd1);
        chk($sformatf("stream%0d_txn", c), 64'(error_txn_id), 64'(12'h100 + 12'(c - 1)));
      end
    end
    apply(4'b0000, 4'hF, 4'h0);
    chk("stream_last_txn", 64'(error_txn_id), 64'h107);
    chk("stream_nodrop", 64'(drop_count), 64'(d0));

    // Drop counter saturation: all sources pulse every cycle, 3 drops per edge after the first.
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 8'h0F, 12'h0, 48'h0);
    for (int c = 0; c < 101; c++) apply(4'b1111, 4'hF, 4'h0);
    chk("sat_mid_drop", 64'(drop_count), 64'd300);
    chk("sat_mid_ovf", 64'(overflow), 64'hF);
    for (int c = 0; c < 21800; c++) apply(4'b1111, 4'hF, 4'h0);
    chk("sat_drop", 64'(drop_count), 64'hFFFF);
    apply(4'b1111, 4'hF, 4'hF);
    chk("sat_set_wins", 64'(overflow), 64'b1110);

    // Asynchronous reset while three slots are pending.
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 8'h0B, 12'(i), 48'(i));
    apply(4'b1111, 4'hF, 4'h0);
    apply(4'b0000, 4'hF, 4'h0);
    chk("pre_rst_valid", 64'(error_valid), 64'd1);
    chk("pre_rst_pend", 64'(pending), 64'b1110);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(error_valid), 64'd0);
    chk("rst_pend", 64'(pending), 64'd0);
    chk("rst_code", 64'(error_code), 64'd0);
    chk("rst_sid", 64'(error_source_id), 64'd0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply(4'b0000, 4'hF, 4'h0);
      chk($sformatf("post_rst%0d_idle", c), 64'(error_valid), 64'd0);
    end
    apply(4'b1001, 4'hF, 4'h0);
    apply(4'b0000, 4'hF, 4'h0);
    chk("post_rst_tie", 64'(error_source_id), 64'h10);
    chk("post_rst_tie_v", 64'(error_valid), 64'd1);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] v, en, clr;
      for (int i = 0; i < N; i++) begin
        logic [7:0] code;
        code = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 5) == 0) code = 8'h00;
        set_src(i, code, 12'($urandom), {16'($urandom), 32'($urandom)});
        v[i] = ($urandom_range(0, 2) == 0);
        en[i] = ($urandom_range(0, 7) != 0);
        clr[i] = ($urandom_range(0, 7) == 0);
      end
      apply(v, en, clr);
      model_step();
      mp = '0;
      mo = '0;
      for (int i = 0; i < N; i++) begin
        mp[i] = m_pend[i];
        mo[i] = m_ovf[i];
      end
      chk($sformatf("rnd%0d_valid", c), 64'(error_valid), 64'(m_ev));
      chk($sformatf("rnd%0d_pend", c), 64'(pending), 64'(mp));
      chk($sformatf("rnd%0d_ovf", c), 64'(overflow), 64'(mo));
      chk($sformatf("rnd%0d_drop", c), 64'(drop_count), 64'(m_drop));
      if (m_ev) begin
        chk($sformatf("rnd%0d_code", c), 64'(error_code), 64'(m_ocode));
        chk($sformatf("rnd%0d_txn", c), 64'(error_txn_id), 64'(m_otxn));
        chk($sformatf("rnd%0d_addr", c), 64'(error_addr), 64'(m_oaddr));
        chk($sformatf("rnd%0d_sid", c), 64'(error_source_id), 64'(m_osid));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
